// File: rtl/es_push_writer.sv
// es_push_writer: buffers producer words in a small FIFO and feeds them to
// the execution stack as single-cycle push commands, holding off while the
// control FSM owns the stack.
// Optional build macro: ES_PUSH_DROP_CNT_EN adds the drop_cnt debug output.
module es_push_writer #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned WIDTH      = 16,
    parameter logic [1:0]  PUSH_OP    = 2'b00,
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     flush,
    input  logic                     es_busy,
    output logic                     ESAct,
    output logic [1:0]               ESop,
    output logic [WIDTH-1:0]         PushVal,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
`ifdef ES_PUSH_DROP_CNT_EN
    ,
    output logic [7:0]               drop_cnt
`endif
);

    localparam int unsigned AW     = $clog2(DEPTH);
    localparam int unsigned CW     = AW + 1;
    localparam int unsigned GW     = 2;
    localparam bit          NO_GAP = (GAP_CYCLES == 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t            state;
    logic [GW-1:0]     gap_cnt;
    logic [WIDTH-1:0]  mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              accept;
    logic              issue_slot;
    logic              pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign in_ready = !full && !reset;
    // flush wins over a simultaneous transfer; that word is dropped
    assign accept   = in_valid && in_ready && !flush;

    // An issue slot opens in IDLE, at the last GAP cycle, or back-to-back
    // from ISSUE when no settle gap is configured.
    assign issue_slot = (state == IDLE)
                     || (state == GAP && gap_cnt == '0)
                     || (state == ISSUE && NO_GAP);
    assign pop = issue_slot && !empty && !es_busy && !flush;

    // FIFO storage write (no reset needed, validity tracked by count)
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + AW'(1);
            if (pop)    rd_ptr <= rd_ptr + AW'(1);
            case ({accept, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Issue FSM with registered stack command outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            gap_cnt <= '0;
            ESAct   <= 1'b0;
            ESop    <= 2'b00;
            PushVal <= '0;
        end else begin
            ESAct <= 1'b0;
            ESop  <= 2'b00;
            if (flush) begin
                state <= IDLE;
            end else if (pop) begin
                state   <= ISSUE;
                ESAct   <= 1'b1;
                ESop    <= PUSH_OP;
                PushVal <= mem[rd_ptr];
            end else begin
                case (state)
                    ISSUE: begin
                        if (NO_GAP) begin
                            state <= IDLE;
                        end else begin
                            state   <= GAP;
                            gap_cnt <= GW'(GAP_CYCLES - 1);
                        end
                    end
                    GAP: begin
                        if (gap_cnt == '0) state <= IDLE;
                        else               gap_cnt <= gap_cnt - GW'(1);
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef ES_PUSH_DROP_CNT_EN
    // Saturating count of offered words that could not be taken
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_cnt <= '0;
        end else if (in_valid && (full || flush) && drop_cnt != 8'hFF) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_es_push_writer.sv
// Randomized bench for es_push_writer against a queue-based reference model.
module tb_es_push_writer;

    localparam int unsigned DEPTH      = 4;
    localparam int unsigned WIDTH      = 16;
    localparam logic [1:0]  PUSH_OP    = 2'b10;
    localparam int unsigned GAP_CYCLES = 1;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_data;
    logic              flush;
    logic              es_busy;
    logic              ESAct;
    logic [1:0]        ESop;
    logic [WIDTH-1:0]  PushVal;
    logic [2:0]        count;
    logic              empty;
    logic              full;
`ifdef ES_PUSH_DROP_CNT_EN
    logic [7:0]        drop_cnt;
`endif

    es_push_writer #(
        .DEPTH(DEPTH), .WIDTH(WIDTH), .PUSH_OP(PUSH_OP), .GAP_CYCLES(GAP_CYCLES)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .flush(flush), .es_busy(es_busy), .ESAct(ESAct),
        .ESop(ESop), .PushVal(PushVal), .count(count), .empty(empty), .full(full)
`ifdef ES_PUSH_DROP_CNT_EN
        , .drop_cnt(drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // reference model: buffered words, cycles before the next push may issue,
    // and the expected stack command outputs
    logic [WIDTH-1:0] q[$];
    int               cooldown;
    logic             m_act;
    logic [WIDTH-1:0] m_val;
    int               m_drop;
    bit               last_acc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        cooldown = 0;
        m_act    = 1'b0;
        m_val    = '0;
        m_drop   = 0;
        last_acc = 1'b0;
    endtask

    // one clock edge of the reference behaviour, using pre-edge state
    task automatic model_edge(input bit v, input logic [WIDTH-1:0] d, input bit fl, input bit busy);
        bit was_full;
        bit acc;
        was_full = (q.size() == DEPTH);
        if (v && (was_full || fl) && m_drop < 255) m_drop++;
        acc = v && !was_full && !fl;
        if (fl) begin
            q.delete();
            cooldown = 0;
            m_act    = 1'b0;
        end else begin
            if (cooldown == 0 && q.size() > 0 && !busy) begin
                m_val    = q.pop_front();
                m_act    = 1'b1;
                cooldown = GAP_CYCLES;
            end else begin
                m_act = 1'b0;
                if (cooldown > 0) cooldown--;
            end
            if (acc) q.push_back(d);
        end
        last_acc = acc;
    endtask

    task automatic check_outputs();
        check("esact",    32'(ESAct),    32'(m_act));
        check("esop",     32'(ESop),     m_act ? 32'(PushVal == PushVal ? PUSH_OP : 2'b00) : 32'd0);
        check("pushval",  32'(PushVal),  32'(m_val));
        check("count",    32'(count),    32'(q.size()));
        check("empty",    32'(empty),    32'(q.size() == 0));
        check("full",     32'(full),     32'(q.size() == DEPTH));
        check("in_ready", 32'(in_ready), 32'((q.size() < DEPTH) && !reset));
`ifdef ES_PUSH_DROP_CNT_EN
        check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
`endif
    endtask

    // drive inputs after a falling edge, advance one clock, check at the next falling edge
    task automatic step(input bit v, input logic [WIDTH-1:0] d, input bit fl, input bit busy);
        in_valid = v;
        in_data  = d;
        flush    = fl;
        es_busy  = busy;
        @(posedge clk);
        model_edge(v, d, fl, busy);
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        bit beef_done;
        bit seen;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        flush    = 1'b0;
        es_busy  = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_outputs();
        reset = 1'b0;
        #1;
        check_outputs();

        // single word goes straight through
        step(1'b1, 16'h1234, 1'b0, 1'b0);
        repeat (4) step(1'b0, 16'h0, 1'b0, 1'b0);

        // burst while the stack is busy, fifth word refused, then drain in order
        for (int i = 1; i <= 5; i++) step(1'b1, WIDTH'(i), 1'b0, 1'b1);
        check("burst_full", 32'(full), 32'd1);
        repeat (12) step(1'b0, 16'h0, 1'b0, 1'b0);

        // full FIFO draining while BEEF is offered until taken
        for (int i = 0; i < 4; i++) step(1'b1, WIDTH'(16'h0100 + i), 1'b0, 1'b1);
        beef_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(!beef_done, 16'hBEEF, 1'b0, 1'b0);
            if (last_acc) beef_done = 1'b1;
        end
        check("beef_taken", 32'(beef_done), 32'd1);
        repeat (6) step(1'b0, 16'h0, 1'b0, 1'b0);

        // flush with three buffered words and a word offered on the same edge
        for (int i = 0; i < 3; i++) step(1'b1, WIDTH'(16'h0200 + i), 1'b0, 1'b1);
        step(1'b1, 16'hAAAA, 1'b1, 1'b1);
        check("flush_count", 32'(count), 32'd0);
        repeat (8) step(1'b0, 16'h0, 1'b0, 1'b0);

        // randomized traffic with varying stack contention
        for (int i = 0; i < 1500; i++) begin
            int busy_pct;
            busy_pct = (i / 250) % 2 == 0 ? 20 : 70;
            step($urandom_range(0, 9) < 7, WIDTH'($urandom),
                 $urandom_range(0, 49) == 0, $urandom_range(0, 99) < busy_pct);
        end

        // asynchronous reset while a push is on the stack bus
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step(1'b1, WIDTH'($urandom | 1), 1'b0, 1'b0);
            if (m_act) seen = 1'b1;
        end
        check("issue_seen", 32'(seen), 32'd1);
        #1 reset = 1'b1;
        #1;
        check("rst_esact",   32'(ESAct),   32'd0);
        check("rst_esop",    32'(ESop),    32'd0);
        check("rst_pushval", 32'(PushVal), 32'd0);
        check("rst_count",   32'(count),   32'd0);
        model_reset();
        check_outputs();
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_outputs();

`ifdef ES_PUSH_DROP_CNT_EN
        // stalled producer saturates the drop counter
        for (int i = 0; i < 4; i++) step(1'b1, WIDTH'(i), 1'b0, 1'b1);
        for (int i = 0; i < 300; i++) step(1'b1, 16'h5555, 1'b0, 1'b1);
        check("drop_sat", 32'(drop_cnt), 32'hFF);
        repeat (10) step(1'b0, 16'h0, 1'b0, 1'b0);
`endif

        repeat (6) step(1'b0, 16'h0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
